// File: rtl/encoder_4_to_2_hs.sv
// Registered 4-to-2 priority encoder with a valid/ready output handshake,
// a multi-hot flag and a saturating count of accepted codes.
module encoder_4_to_2_hs #(
  parameter int EDGE_MODE = 0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EN,
  input  logic             D0,
  input  logic             D1,
  input  logic             D2,
  input  logic             D3,
  input  logic             READY,
  output logic             A1,
  output logic             A0,
  output logic             VALID,
  output logic             MULTI,
  output logic [CNT_W-1:0] EVT_CNT
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [3:0]         d_vec, prev_q, q_vec;
  logic [1:0]         a_q, a_d, idx;
  logic               multi_q, multi_d, multi_n;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cap, acc, load;

  assign d_vec = {D3, D2, D1, D0};
  // Edge mode only counts bits that were low on the previous edge.
  assign q_vec = (EDGE_MODE != 0) ? (d_vec & ~prev_q) : d_vec;
  assign cap   = EN & (|q_vec);

  always_comb begin
    idx = 2'd0;
    casez (q_vec)
      4'b1???: idx = 2'd3;
      4'b01??: idx = 2'd2;
      4'b001?: idx = 2'd1;
      default: idx = 2'd0;
    endcase
  end

  assign multi_n = ($countones(q_vec) > 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prev_q  <= 4'b0000;
      a_q     <= 2'b00;
      multi_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= d_vec;
      a_q     <= a_d;
      multi_q <= multi_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cap) state_d = HOLD;
      HOLD:    if (READY && !cap) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A new code loads when the slot is empty or is being emptied this edge.
  always_comb begin
    acc     = (state_q == HOLD) & READY;
    load    = cap & ((state_q == IDLE) | READY);
    a_d     = load ? idx : a_q;
    multi_d = load ? multi_n : multi_q;
    cnt_d   = (acc && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  assign A1      = a_q[1];
  assign A0      = a_q[0];
  assign VALID   = (state_q == HOLD);
  assign MULTI   = multi_q;
  assign EVT_CNT = cnt_q;

endmodule

// File: tb/tb_encoder_4_to_2_hs.sv
// Bench for encoder_4_to_2_hs: three instances (level, edge, narrow counter)
// driven from shared stimulus and compared against a behavioural model.
module tb_encoder_4_to_2_hs;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, ready = 1'b0;
  logic [3:0] d = 4'b0000;

  logic [2:0] a1_w, a0_w, valid_w, multi_w;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int checks = 0;
  int failures = 0;

  // Model state per instance
  logic [3:0] m_prev[3];
  bit         m_valid[3];
  logic [1:0] m_a[3];
  bit         m_multi[3];
  int         m_cnt[3];
  int         edge_mode[3] = '{0, 1, 0};
  int         cmax[3]      = '{255, 255, 3};

  always #5 clk = ~clk;

  encoder_4_to_2_hs #(.EDGE_MODE(0), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .EN(en), .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .READY(ready), .A1(a1_w[0]), .A0(a0_w[0]), .VALID(valid_w[0]), .MULTI(multi_w[0]),
    .EVT_CNT(cnt0));
  encoder_4_to_2_hs #(.EDGE_MODE(1), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .EN(en), .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .READY(ready), .A1(a1_w[1]), .A0(a0_w[1]), .VALID(valid_w[1]), .MULTI(multi_w[1]),
    .EVT_CNT(cnt1));
  encoder_4_to_2_hs #(.EDGE_MODE(0), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .EN(en), .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .READY(ready), .A1(a1_w[2]), .A0(a0_w[2]), .VALID(valid_w[2]), .MULTI(multi_w[2]),
    .EVT_CNT(cnt2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_prev[i] = 4'b0000; m_valid[i] = 0; m_a[i] = 2'b00; m_multi[i] = 0; m_cnt[i] = 0;
    end
  endtask

  // One clock edge of the intended behaviour, from the request rules.
  task automatic model_edge();
    logic [3:0] q;
    int hi;
    for (int i = 0; i < 3; i++) begin
      q = (edge_mode[i] != 0) ? (d & ~m_prev[i]) : d;
      if (m_valid[i] && ready && m_cnt[i] < cmax[i]) m_cnt[i]++;
      if (en && q != 0 && (!m_valid[i] || ready)) begin
        hi = 0;
        for (int b = 0; b < 4; b++) if (q[b]) hi = b;
        m_valid[i] = 1;
        m_a[i]     = 2'(hi);
        m_multi[i] = ($countones(q) > 1);
      end else if (m_valid[i] && ready) begin
        m_valid[i] = 0;
      end
      m_prev[i] = d;
    end
  endtask

  function automatic int cnt_of(input int i);
    case (i)
      0: return int'(cnt0);
      1: return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("valid%0d", i), 32'(valid_w[i]), 32'(m_valid[i]));
      chk($sformatf("code%0d", i), 32'({a1_w[i], a0_w[i]}), 32'(m_a[i]));
      chk($sformatf("multi%0d", i), 32'(multi_w[i]), 32'(m_multi[i]));
      chk($sformatf("cnt%0d", i), 32'(cnt_of(i)), 32'(m_cnt[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();
    check_all();

    // Disabled capture ignores requests
    en = 0; d = 4'b1111; ready = 0;
    repeat (4) step();
    chk("t1_valid", 32'(valid_w[0]), 32'd0);
    chk("t1_code", 32'({a1_w[0], a0_w[0]}), 32'd0);
    chk("t1_cnt", 32'(cnt0), 32'd0);

    // Held code is stable while READY is low
    en = 1; d = 4'b0100; step();
    chk("t2_valid", 32'(valid_w[0]), 32'd1);
    chk("t2_code", 32'({a1_w[0], a0_w[0]}), 32'd2);
    chk("t2_multi", 32'(multi_w[0]), 32'd0);
    d = 4'b1000; step(); step();
    chk("t2_hold", 32'({a1_w[0], a0_w[0]}), 32'd2);

    // Back-to-back accept with multi-hot capture, then drain
    d = 4'b1011; ready = 1; step();
    chk("t3_code", 32'({a1_w[0], a0_w[0]}), 32'd3);
    chk("t3_multi", 32'(multi_w[0]), 32'd1);
    d = 4'b0000; step();
    chk("t3_drop", 32'(valid_w[0]), 32'd0);

    // Streaming one code per cycle
    foreach (d[k]) begin end
    for (int k = 0; k < 4; k++) begin
      d = 4'(1 << k); step();
      chk("t4_code", 32'({a1_w[0], a0_w[0]}), 32'(k));
      chk("t4_valid", 32'(valid_w[0]), 32'd1);
    end
    d = 4'b0000; step();

    // Edge mode: a held request yields a single code
    do_reset();
    en = 1; ready = 1; d = 4'b0010; step();
    chk("t5_code", 32'({a1_w[1], a0_w[1]}), 32'd1);
    repeat (4) step();
    chk("t5_idle", 32'(valid_w[1]), 32'd0);
    chk("t5_cnt", 32'(cnt1), 32'd1);
    d = 4'b0011; step();
    chk("t5_new", 32'({a1_w[1], a0_w[1]}), 32'd0);
    chk("t5_valid", 32'(valid_w[1]), 32'd1);
    chk("t5_multi", 32'(multi_w[1]), 32'd0);
    d = 4'b0000; step();

    // Asynchronous reset while a code is pending
    ready = 0; d = 4'b1100; step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_valid", 32'(valid_w[0]), 32'd0);
    chk("t6_code", 32'({a1_w[0], a0_w[0]}), 32'd0);
    chk("t6_multi", 32'(multi_w[0]), 32'd0);
    chk("t6_cnt", 32'(cnt0), 32'd0);
    #1 rst_n = 1'b1;
    d = 4'b0000; en = 0;
    @(negedge clk);

    // Narrow counter saturates
    en = 1; ready = 1; d = 4'b0001;
    repeat (6) step();
    chk("t6_sat2", 32'(cnt2), 32'd3);
    chk("t6_cnt8", 32'(cnt0), 32'd5);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      d     = 4'($urandom_range(0, 15));
      en    = ($urandom_range(0, 3) != 0);
      ready = 1'($urandom_range(0, 1));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
